// File: rtl/mem_pkg.sv
// Shared definitions for the memory-stage load/store unit: funct3 access encodings
// and the transaction FSM state type.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [0:0] {
    IDLE,
    WAIT
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store-side byte enables/replicated data/legality check,
// and load-side lane select with sign or zero extension.
module lsu_align
  import mem_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_off,
  input  logic        st_is_load,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  output logic        st_legal,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_be    = 4'b0000;
    st_wdata = 32'd0;
    st_legal = 1'b0;
    case (st_funct3)
      F3_B, F3_BU: begin
        st_be    = 4'b0001 << st_off;
        st_wdata = {4{st_data[7:0]}};
        // Unsigned variants only exist for loads.
        st_legal = (st_funct3 == F3_B) | st_is_load;
      end
      F3_H, F3_HU: begin
        st_be    = 4'b0011 << st_off;
        st_wdata = {2{st_data[15:0]}};
        st_legal = ~st_off[0] & ((st_funct3 == F3_H) | st_is_load);
      end
      F3_W: begin
        st_be    = 4'b1111;
        st_wdata = st_data;
        st_legal = (st_off == 2'b00);
      end
      default: begin
        st_be    = 4'b0000;
        st_wdata = 32'd0;
        st_legal = 1'b0;
      end
    endcase
  end

  always_comb begin
    ld_byte = 8'd0;
    unique case (ld_off)
      2'd0: ld_byte = ld_rdata[7:0];
      2'd1: ld_byte = ld_rdata[15:8];
      2'd2: ld_byte = ld_rdata[23:16];
      2'd3: ld_byte = ld_rdata[31:24];
      default: ld_byte = 8'd0;
    endcase
    ld_half = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];
  end

  always_comb begin
    ld_data = 32'd0;
    case (ld_funct3)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data = {24'd0, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data = {16'd0, ld_half};
      F3_W:    ld_data = ld_rdata;
      default: ld_data = 32'd0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: issues req/ready data-memory transactions, holds the
// pipeline while waiting, and aborts with a fault on misalignment, bad funct3 or timeout.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] data_address_in,
  input  logic [31:0] store_data_in,
  input  logic [4:0]  read_rd_in,
  input  logic        reg_write_in,
  input  logic        mem_to_reg_in,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  output logic        mem_stall,
  output logic        mem_fault,
  output logic [31:0] data_mem_out,
  output logic [31:0] data_address_out,
  output logic [4:0]  read_rd_out,
  output logic        reg_write_out,
  output logic        mem_to_reg_out
);

  localparam logic [7:0] TimeoutLoad = 8'(TIMEOUT_CYCLES);

  lsu_state_t  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [4:0]  rd_q;
  logic        reg_write_q, mem_to_reg_q;

  logic        active, load_latch;
  logic        req_c, fault_c, complete, cur_load;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_off;
  logic [3:0]  be_in;
  logic [31:0] wdata_in, ld_data;
  logic        legal_in;

  assign active = mem_read_in | mem_write_in;

  lsu_align u_align (
    .st_funct3  (funct3_in),
    .st_off     (data_address_in[1:0]),
    .st_is_load (mem_read_in),
    .st_data    (store_data_in),
    .st_be      (be_in),
    .st_wdata   (wdata_in),
    .st_legal   (legal_in),
    .ld_funct3  (ld_funct3),
    .ld_off     (ld_off),
    .ld_rdata   (dmem_rdata),
    .ld_data    (ld_data)
  );

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    load_latch       = 1'b0;
    req_c            = 1'b0;
    fault_c          = 1'b0;
    complete         = 1'b0;
    mem_stall        = 1'b0;
    dmem_we          = 1'b0;
    dmem_addr        = {data_address_in[31:2], 2'b00};
    dmem_be          = be_in;
    dmem_wdata       = wdata_in;
    cur_load         = mem_read_in;
    ld_funct3        = funct3_in;
    ld_off           = data_address_in[1:0];
    data_address_out = data_address_in;
    read_rd_out      = read_rd_in;
    reg_write_out    = reg_write_in;
    mem_to_reg_out   = mem_to_reg_in;

    unique case (state_q)
      IDLE: begin
        if (active) begin
          if (legal_in) begin
            req_c   = 1'b1;
            dmem_we = ~mem_read_in;
            if (dmem_ready) begin
              complete = 1'b1;
            end else begin
              mem_stall  = 1'b1;
              load_latch = 1'b1;
              cnt_d      = TimeoutLoad;
              state_d    = WAIT;
            end
          end else begin
            fault_c        = 1'b1;
            reg_write_out  = 1'b0;
            mem_to_reg_out = 1'b0;
          end
        end
      end
      WAIT: begin
        // Request and passthroughs come from the latched copy so upstream may change.
        req_c            = 1'b1;
        dmem_we          = we_q;
        dmem_addr        = {addr_q[31:2], 2'b00};
        dmem_be          = be_q;
        dmem_wdata       = wdata_q;
        cur_load         = ~we_q;
        ld_funct3        = funct3_q;
        ld_off           = addr_q[1:0];
        data_address_out = addr_q;
        read_rd_out      = rd_q;
        reg_write_out    = reg_write_q;
        mem_to_reg_out   = mem_to_reg_q;
        if (dmem_ready) begin
          complete = 1'b1;
          cnt_d    = 8'd0;
          state_d  = IDLE;
        end else if (cnt_q <= 8'd1) begin
          fault_c        = 1'b1;
          reg_write_out  = 1'b0;
          mem_to_reg_out = 1'b0;
          cnt_d          = 8'd0;
          state_d        = IDLE;
        end else begin
          mem_stall = 1'b1;
          cnt_d     = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase

    data_mem_out = (complete & cur_load) ? ld_data : 32'd0;
  end

  // Reset must drop the request immediately, even while upstream still presents an access.
  assign dmem_req  = req_c & resetn;
  assign mem_fault = fault_c & resetn;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      be_q         <= 4'd0;
      we_q         <= 1'b0;
      funct3_q     <= 3'd0;
      rd_q         <= 5'd0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load_latch) begin
        addr_q       <= data_address_in;
        wdata_q      <= wdata_in;
        be_q         <= be_in;
        we_q         <= ~mem_read_in;
        funct3_q     <= funct3_in;
        rd_q         <= read_rd_in;
        reg_write_q  <= reg_write_in;
        mem_to_reg_q <= mem_to_reg_in;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a transaction-level model.
module tb_mem_access_unit;

  localparam int T = 4;

  logic        clock = 1'b0;
  logic        resetn;
  logic        mem_read_in, mem_write_in;
  logic [2:0]  funct3_in;
  logic [31:0] data_address_in, store_data_in;
  logic [4:0]  read_rd_in;
  logic        reg_write_in, mem_to_reg_in;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        dmem_req, dmem_we, mem_stall, mem_fault;
  logic [31:0] dmem_addr, dmem_wdata, data_mem_out, data_address_out;
  logic [3:0]  dmem_be;
  logic [4:0]  read_rd_out;
  logic        reg_write_out, mem_to_reg_out;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        rd_en;
    logic        wr_en;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        rw;
    logic        m2r;
  } txn_t;

  typedef struct packed {
    logic        req, we, stall, fault, rw, m2r, done, tmo, start;
    logic [31:0] addr, wdata, dout, aout;
    logic [3:0]  be;
    logic [4:0]  rd;
  } exp_t;

  mem_access_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clock            (clock),
    .resetn           (resetn),
    .mem_read_in      (mem_read_in),
    .mem_write_in     (mem_write_in),
    .funct3_in        (funct3_in),
    .data_address_in  (data_address_in),
    .store_data_in    (store_data_in),
    .read_rd_in       (read_rd_in),
    .reg_write_in     (reg_write_in),
    .mem_to_reg_in    (mem_to_reg_in),
    .dmem_ready       (dmem_ready),
    .dmem_rdata       (dmem_rdata),
    .dmem_req         (dmem_req),
    .dmem_we          (dmem_we),
    .dmem_addr        (dmem_addr),
    .dmem_be          (dmem_be),
    .dmem_wdata       (dmem_wdata),
    .mem_stall        (mem_stall),
    .mem_fault        (mem_fault),
    .data_mem_out     (data_mem_out),
    .data_address_out (data_address_out),
    .read_rd_out      (read_rd_out),
    .reg_write_out    (reg_write_out),
    .mem_to_reg_out   (mem_to_reg_out)
  );

  initial forever #5 clock = ~clock;

  // Transaction-level model: what the outputs must be this cycle, from the access rules.
  function automatic exp_t model_eval(input logic busy, input txn_t tin, input txn_t tlat,
                                      input int waits, input logic rdy,
                                      input logic [31:0] rdata);
    exp_t e;
    txn_t c;
    int nb, off;
    logic ld, ok;
    logic [31:0] v;
    c = busy ? tlat : tin;
    e = '0;
    e.rd = c.rd; e.aout = c.addr; e.rw = c.rw; e.m2r = c.m2r;
    if (!busy && !(c.rd_en || c.wr_en)) return e;
    ld  = c.rd_en;
    off = int'(c.addr[1:0]);
    nb  = 1 << c.f3[1:0];
    ok  = (c.f3 <= 3'd2) || (ld && (c.f3 == 3'd4 || c.f3 == 3'd5));
    ok  = ok && ((off % nb) == 0);
    if (!ok) begin
      e.fault = 1'b1; e.rw = 1'b0; e.m2r = 1'b0;
      return e;
    end
    e.req   = 1'b1;
    e.we    = !ld;
    e.addr  = c.addr & 32'hFFFF_FFFC;
    e.be    = 4'(((1 << nb) - 1) << off);
    e.wdata = (nb == 1) ? 32'(c.sd[7:0]) * 32'h0101_0101 :
              (nb == 2) ? 32'(c.sd[15:0]) * 32'h0001_0001 : c.sd;
    if (rdy) begin
      e.done = 1'b1;
      if (ld) begin
        v = rdata >> (8 * off);
        if (nb == 1) begin
          v = v & 32'hFF;
          if (!c.f3[2] && v[7]) v = v - 32'd256;
        end else if (nb == 2) begin
          v = v & 32'hFFFF;
          if (!c.f3[2] && v[15]) v = v - 32'd65536;
        end
        e.dout = v;
      end
    end else if (busy && (waits + 1 == T)) begin
      e.tmo = 1'b1; e.fault = 1'b1; e.rw = 1'b0; e.m2r = 1'b0;
    end else begin
      e.stall = 1'b1;
      e.start = !busy;
    end
    return e;
  endfunction

  logic mdl_busy;
  txn_t mdl_lat, cur_t;
  int   mdl_waits;
  exp_t mdl_e;

  always_comb begin
    cur_t = '{rd_en: mem_read_in, wr_en: mem_write_in, f3: funct3_in,
              addr: data_address_in, sd: store_data_in, rd: read_rd_in,
              rw: reg_write_in, m2r: mem_to_reg_in};
    mdl_e = model_eval(mdl_busy, cur_t, mdl_lat, mdl_waits, dmem_ready, dmem_rdata);
  end

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mdl_busy  <= 1'b0;
      mdl_waits <= 0;
    end else if (mdl_e.start) begin
      mdl_busy  <= 1'b1;
      mdl_lat   <= cur_t;
      mdl_waits <= 0;
    end else if (mdl_busy) begin
      if (mdl_e.done || mdl_e.tmo) mdl_busy <= 1'b0;
      else mdl_waits <= mdl_waits + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_cycle();
    chk("req", 32'(dmem_req), 32'(mdl_e.req));
    chk("stall", 32'(mem_stall), 32'(mdl_e.stall));
    chk("fault", 32'(mem_fault), 32'(mdl_e.fault));
    chk("dout", data_mem_out, mdl_e.dout);
    chk("aout", data_address_out, mdl_e.aout);
    chk("rd", 32'(read_rd_out), 32'(mdl_e.rd));
    chk("rw", 32'(reg_write_out), 32'(mdl_e.rw));
    chk("m2r", 32'(mem_to_reg_out), 32'(mdl_e.m2r));
    if (mdl_e.req) begin
      chk("we", 32'(dmem_we), 32'(mdl_e.we));
      chk("addr", dmem_addr, mdl_e.addr);
      chk("be", 32'(dmem_be), 32'(mdl_e.be));
      chk("wdata", dmem_wdata, mdl_e.wdata);
    end
  endtask

  always @(negedge clock) begin
    if (resetn) compare_cycle();
  end

  task automatic drive(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sd, input logic rdy,
                       input logic [31:0] rdata);
    mem_read_in = rd_en; mem_write_in = wr_en; funct3_in = f3;
    data_address_in = addr; store_data_in = sd; read_rd_in = 5'd7;
    reg_write_in = rd_en; mem_to_reg_in = rd_en;
    dmem_ready = rdy; dmem_rdata = rdata;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  int req_cnt, fault_at;
  logic [31:0] rnd;
  int rdy_div;

  initial begin
    resetn = 1'b0;
    drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    next_cycle();
    next_cycle();
    chk("reset_req", 32'(dmem_req), 32'd0);
    chk("reset_fault", 32'(mem_fault), 32'd0);
    chk("reset_stall", 32'(mem_stall), 32'd0);
    chk("reset_dout", data_mem_out, 32'd0);
    resetn = 1'b1;
    next_cycle();

    // Zero-wait LW.
    drive(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 1'b1, 32'hDEAD_BEEF);
    #2;
    chk("lw_req", 32'(dmem_req), 32'd1);
    chk("lw_stall", 32'(mem_stall), 32'd0);
    chk("lw_data", data_mem_out, 32'hDEAD_BEEF);

    // LB / LBU at 0x103 with three wait cycles.
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      drive(1'b1, 1'b0, (k == 0) ? 3'b000 : 3'b100, 32'h103, 32'd0, 1'b0, 32'h80FF_FFFF);
      for (int i = 0; i < 3; i++) begin
        #2;
        chk("lb_stall_wait", 32'(mem_stall), 32'd1);
        next_cycle();
      end
      dmem_ready = 1'b1;
      #2;
      chk("lb_stall_done", 32'(mem_stall), 32'd0);
      chk("lb_data", data_mem_out, (k == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
    end

    // SH at 0x202.
    next_cycle();
    drive(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 1'b1, 32'd0);
    #2;
    chk("sh_be", 32'(dmem_be), 32'b1100);
    chk("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
    chk("sh_addr", dmem_addr, 32'h200);
    chk("sh_we", 32'(dmem_we), 32'd1);
    chk("sh_dout", data_mem_out, 32'd0);

    // Misaligned LW.
    next_cycle();
    drive(1'b1, 1'b0, 3'b010, 32'h101, 32'd0, 1'b0, 32'd0);
    #2;
    chk("mis_req", 32'(dmem_req), 32'd0);
    chk("mis_fault", 32'(mem_fault), 32'd1);
    chk("mis_rw", 32'(reg_write_out), 32'd0);
    chk("mis_stall", 32'(mem_stall), 32'd0);
    next_cycle();
    drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    #2;
    chk("mis_fault_clear", 32'(mem_fault), 32'd0);

    // Timeout with ready held low.
    next_cycle();
    drive(1'b1, 1'b0, 3'b010, 32'h40, 32'd0, 1'b0, 32'd0);
    req_cnt = 0;
    fault_at = -1;
    for (int i = 0; i < 10; i++) begin
      #2;
      if (dmem_req) req_cnt++;
      if (mem_fault) begin
        fault_at = i;
        chk("tmo_stall", 32'(mem_stall), 32'd0);
        chk("tmo_rw", 32'(reg_write_out), 32'd0);
        break;
      end
      next_cycle();
    end
    chk("tmo_req_cycles", 32'(req_cnt), 32'd5);
    chk("tmo_fault_cycle", 32'(fault_at), 32'd4);
    next_cycle();
    drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    #2;
    chk("tmo_idle_req", 32'(dmem_req), 32'd0);

    // Ready arriving on the last WAIT cycle wins over the timeout.
    next_cycle();
    drive(1'b1, 1'b0, 3'b010, 32'h44, 32'd0, 1'b0, 32'h5A5A_0001);
    for (int i = 0; i < 4; i++) next_cycle();
    dmem_ready = 1'b1;
    #2;
    chk("last_fault", 32'(mem_fault), 32'd0);
    chk("last_stall", 32'(mem_stall), 32'd0);
    chk("last_data", data_mem_out, 32'h5A5A_0001);
    next_cycle();
    drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 32'd0);

    // Reset during WAIT with the access still presented upstream.
    next_cycle();
    drive(1'b1, 1'b0, 3'b010, 32'h80, 32'd0, 1'b0, 32'd0);
    next_cycle();
    #1;
    chk("rst_wait_req", 32'(dmem_req), 32'd1);
    resetn = 1'b0;
    #1;
    chk("rst_req_drop", 32'(dmem_req), 32'd0);
    chk("rst_no_fault", 32'(mem_fault), 32'd0);
    next_cycle();
    resetn = 1'b1;
    dmem_ready = 1'b1;
    dmem_rdata = 32'h1122_3344;
    #2;
    chk("rst_new_stall", 32'(mem_stall), 32'd0);
    chk("rst_new_data", data_mem_out, 32'h1122_3344);
    next_cycle();

    // Random traffic; inputs also change during WAIT to exercise the latched request.
    for (int i = 0; i < 1500; i++) begin
      rdy_div = (i < 750) ? 2 : 7;
      rnd = $urandom;
      mem_read_in     = (rnd[1:0] == 2'd0);
      mem_write_in    = (rnd[3:2] == 2'd0);
      funct3_in       = (rnd[4]) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
      data_address_in = $urandom;
      if (rnd[5]) data_address_in[1:0] = 2'b00;
      store_data_in   = $urandom;
      read_rd_in      = 5'($urandom);
      reg_write_in    = rnd[6];
      mem_to_reg_in   = rnd[7];
      dmem_ready      = ($urandom_range(0, rdy_div - 1) == 0);
      dmem_rdata      = $urandom;
      next_cycle();
    end

    drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    next_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store unit. It sits between the EX/MEM pipeline register and the MEM/WB register (`mem_wb_unit`). It turns `mem_read`/`mem_write` requests into req/ready transactions on the data-memory port. For loads it extracts and extends the read data into `data_mem_out`. It holds the pipeline through `mem_stall` until each transaction completes or times out.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 16: maximum number of WAIT cycles before the transaction is abandoned; range 1..255.

Ports:
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `mem_read_in`  in  1  load request from EX/MEM.
- `mem_write_in`  in  1  store request from EX/MEM.
- `funct3_in`  in  3  access size and sign (RV32I encoding).
- `data_address_in`  in  32  ALU result, i.e. the byte address.
- `store_data_in`  in  32  rs2 value for stores.
- `read_rd_in`  in  5  destination register.
- `reg_write_in`, `mem_to_reg_in`  in  1 each  WB controls.
- `dmem_ready`  in  1  memory completes the access this cycle.
- `dmem_rdata`  in  32  aligned read word; valid when `dmem_ready`.
- `dmem_req`  out  1  access request.
- `dmem_we`  out  1  1 = write.
- `dmem_addr`  out  32  word-aligned address; `[1:0]` = 0.
- `dmem_be`  out  4  byte enables.
- `dmem_wdata`  out  32  lane-replicated store data.
- `mem_stall`  out  1  freeze PC/IF/ID/EX/MEM; drives `mem_wb_unit.stall` = 0 and `flush` per the rules below.
- `mem_fault`  out  1  one-cycle pulse on misaligned access, illegal `funct3`, or timeout.
- `data_mem_out`  out  32  extended load data.
- `data_address_out`  out  32  address passthrough.
- `read_rd_out`  out  5  rd passthrough.
- `reg_write_out`, `mem_to_reg_out`  out  1 each  WB controls (suppressed on fault).

## Operation
- An access is active when `mem_read_in | mem_write_in`. If both are set, the read wins.
- Sizes:
  - `funct3` 000 = B, 001 = H, 010 = W, 100 = BU, 101 = HU. BU and HU are loads only.
  - Any other `funct3` is illegal.
  - H requires `addr[0]` = 0. W requires `addr[1:0]` = 0.
- Byte enables: `dmem_be` = `0001<<off` for B, `0011<<off` for H, `1111` for W, where `off = addr[1:0]`.
- Store data: `dmem_wdata` = `{4{sd[7:0]}}` for B, `{2{sd[15:0]}}` for H, `sd` for W.
- Load data: select the lane at `off`, then sign- or zero-extend per `funct3`.
- FSM states: IDLE, WAIT.
  - IDLE, legal access:
    - `dmem_req` = 1 combinationally from the inputs.
    - If `dmem_ready` = 1: the access completes with zero wait and the FSM stays in IDLE.
    - Otherwise: latch addr, be, wdata, we, funct3, off, rd and controls; load the counter with `TIMEOUT_CYCLES`; go to WAIT.
  - IDLE, illegal or misaligned access:
    - No request is issued.
    - `mem_fault` = 1 and `reg_write_out` = 0 for that cycle.
    - `mem_stall` = 0.
  - WAIT:
    - `dmem_req` = 1 from the latched registers. The request must not change until complete.
    - `mem_stall` = 1 until completion.
    - Each cycle with `dmem_ready` = 0, the counter decrements.
    - On `dmem_ready`: complete and return to IDLE.
    - When the counter reaches 0 with no ready: drop `dmem_req`, pulse `mem_fault`, force `reg_write_out` = 0, return to IDLE.
- Completion cycle:
  - `mem_stall` = 0 and the MEM/WB register latches.
  - `data_mem_out` = extended `dmem_rdata` for loads, 0 for stores.
  - All passthrough outputs come from the latched copy (from WAIT) or from the inputs (zero-wait case).
- No active access: `dmem_req` = 0, `mem_stall` = 0, the WB controls pass through, and `data_mem_out` = 0.
- Stores are never cancelled once `dmem_req` is asserted.

## Timing
- Reset (async, immediate):
  - Forced outputs: FSM = IDLE, counter = 0, latches = 0, `dmem_req` = 0 and `mem_fault` = 0.
  - Combinational outputs follow the IDLE equations.
- Latency: 1 cycle of MEM occupancy for a zero-wait access; N+1 cycles for N wait cycles.
- Handshake: a transfer occurs on the rising edge where `dmem_req` = `dmem_ready` = 1.
- `dmem_ready` while `dmem_req` = 0 is ignored.
- Timeout fires on the `TIMEOUT_CYCLES`-th WAIT cycle without ready. A `dmem_ready` arriving in that same cycle completes the access normally; ready wins.
- Reset asserted mid-WAIT: the request is dropped immediately and no fault is raised.
- Back-to-back accesses: the next access may be issued in the first IDLE cycle after completion.

## Structure
- Shared package `mem_pkg`:
  - `funct3` localparams (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`).
  - `lsu_state_t` enum {IDLE, WAIT}.
- Sub-module `lsu_align` (combinational), with two paths:
  - Store side: funct3/offset → be/wdata/legal.
  - Load side: rdata/funct3/offset → extended data.
- The FSM, counter and latches live in `mem_access_unit`.

## Test plan
- LW at 0x100, `dmem_ready` = 1 on the request cycle, `rdata` 0xDEADBEEF → `mem_stall` never asserted; `data_mem_out` = 0xDEADBEEF in the same cycle.
- LB at 0x103, `rdata` 0x80FFFFFF after 3 wait cycles → `mem_stall` high for 3 cycles; `data_mem_out` = 0xFFFFFF80. LBU with the same stimulus → 0x00000080.
- SH at 0x202, `store_data` 0x1234ABCD → `dmem_be` = 1100, `dmem_wdata` = 0xABCDABCD, `dmem_addr` = 0x200, `dmem_we` = 1.
- LW at 0x101 → no `dmem_req`; `mem_fault` pulses 1 cycle; `reg_write_out` = 0.
- `TIMEOUT_CYCLES` = 4, `dmem_ready` held low → `dmem_req` high for 5 cycles (1 IDLE + 4 WAIT), then `mem_fault` pulses and stall releases. Repeat with ready arriving on WAIT cycle 4 → normal completion, no fault.
- `resetn` pulsed low during WAIT → `dmem_req` falls asynchronously and FSM = IDLE; a new LW after reset completes normally.
